main_blink: RTL and testbench

//   Free-running LED blinker and top-level demo block for the multi-board examples.

---
 rtl/main_blink.sv | 66 ++++++
 tb/tb_main_blink.sv | 98 +++++++++
 2 files changed

// File: rtl/main_blink.sv
// rtl/main_blink.sv - free-running LED blinker dividing CLK into a CLKS_PER_CYCLE-period square wave
// Optional MAIN_BLINK_INVERT_EN drives LED from an inverted register for active-low LED boards.
module main_blink #(
   parameter int CLKS_PER_CYCLE = 12_000_000
) (
   input  logic CLK,
   input  logic RST,
   output logic LED
);

   localparam int             W    = (CLKS_PER_CYCLE > 2) ? $clog2(CLKS_PER_CYCLE) : 1;
   localparam logic [W-1:0]   LAST = W'(CLKS_PER_CYCLE - 1);
   localparam logic [W-1:0]   HALF = W'(CLKS_PER_CYCLE / 2);

   generate
      if (CLKS_PER_CYCLE < 2) begin : g_bad_period
         $error("main_blink: CLKS_PER_CYCLE must be >= 2");
      end
   endgenerate

   // Initialisers let the block run from power-up on boards with RST tied low.
   logic [W-1:0] cnt = '0;
   logic [W-1:0] cnt_next;
   logic         led_on;

   always_comb begin
      cnt_next = (cnt == LAST) ? '0 : cnt + W'(1);
      led_on   = (cnt_next >= HALF);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

`ifdef MAIN_BLINK_INVERT_EN
   // Inversion lives in the register so the pin stays glitch-free; reset value means LED off.
   logic led_n = 1'b1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         led_n <= 1'b1;
      end else begin
         led_n <= ~led_on;
      end
   end

   assign LED = led_n;
`else
   logic led_q = 1'b0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         led_q <= 1'b0;
      end else begin
         led_q <= led_on;
      end
   end

   assign LED = led_q;
`endif

endmodule

// File: tb/tb_main_blink.sv
// tb/tb_main_blink.sv - scoreboard bench for main_blink with periods 6 and 7
// Expected LED per edge comes from hand-written tables; honours MAIN_BLINK_INVERT_EN.
module tb_main_blink;

   logic clk  = 1'b0;
   logic rst6 = 1'b0;
   logic rst7 = 1'b0;
   logic led6;
   logic led7;

   main_blink #(.CLKS_PER_CYCLE(6)) dut6 (.CLK(clk), .RST(rst6), .LED(led6));
   main_blink #(.CLKS_PER_CYCLE(7)) dut7 (.CLK(clk), .RST(rst7), .LED(led7));

   always #5 clk = ~clk;

`ifdef MAIN_BLINK_INVERT_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif

   localparam int NVEC = 43;

   // Index 0 is the power-up state; index k is the state after edge k.
   // Period 6: free run 1-16, reset at 17, run 18-23, reset held 24-33, run 34-42.
   string exp6_s = {"0", "0011100011100011", "0", "001110", "0000000000", "001110001"};
   string rst6_s = {"0", "0000000000000000", "1", "000000", "1111111111", "000000000"};
   // Period 7 free-runs from power-up: low 3, high 4.
   string exp7_s = {"0", "0011110", "0011110", "0011110", "0011110", "0011110", "0011110"};

   typedef struct {
      int   idx;
      logic e6;
      logic e7;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input int idx, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s after edge %0d: LED=%b expected %b", name, idx, act, req);
      end
   endtask

   task automatic push(input int i);
      exp_t e;
      e.idx = i;
      e.e6  = (exp6_s[i] == "1") ^ INV;
      e.e7  = (exp7_s[i] == "1") ^ INV;
      sb.push_back(e);
   endtask

   initial begin
      rst6 = 1'b0;
      push(0);
      for (int i = 1; i < NVEC; i++) begin
         rst6 = (rst6_s[i] == "1");
         push(i);
         @(posedge clk);
         #1;
      end
      rst6 = 1'b0;
   end

   initial begin
      exp_t e;
      int   got;
      got = 0;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("powerup_p6", e.idx, led6, e.e6);
         check("powerup_p7", e.idx, led7, e.e7);
         got++;
      end
      for (int n = 0; n < 60 && got < NVEC; n++) begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("led_p6", e.idx, led6, e.e6);
            check("led_p7", e.idx, led7, e.e7);
            got++;
         end
      end
      if (got < NVEC) begin
         tests++;
         fails++;
         $display("FAIL scoreboard_drain: checked %0d vectors, required %0d", got, NVEC);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
